// File: rtl/udp_seq_engine.sv
// Table-driven sequential UDP evaluator: run-time loaded rows of level/edge/state/output
// terms are matched against a 3-valued input vector on every in_valid strobe.
module udp_seq_engine #(
  parameter int         N_IN  = 2,
  parameter int         DEPTH = 16,
  parameter logic [1:0] INIT  = 2'b10,
  localparam int        AW    = $clog2(DEPTH),
  localparam int        ROW_W = 9*N_IN + 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [ROW_W-1:0]  cfg_wdata,
  input  logic              in_valid,
  input  logic [2*N_IN-1:0] in_val,
  output logic [1:0]        q,
  output logic              q_valid,
  output logic              hit,
  output logic [AW-1:0]     hit_idx,
  output logic              uncov
);

  logic [ROW_W-1:0]  tbl [DEPTH];
  logic [2*N_IN-1:0] prev;
  logic              found;
  logic [AW-1:0]     idx;
  logic              changed;
  logic [1:0]        row_out;
  logic [1:0]        q_next;

  // 00 -> 0, 01 -> 1, 1? -> 2 (x); codes 10 and 11 collapse to the same index
  function automatic int vidx(input logic [1:0] c);
    return c[1] ? 2 : (c[0] ? 1 : 0);
  endfunction

  function automatic logic row_match(input logic [ROW_W-1:0] row, input logic [1:0] qc,
                                     input logic [2*N_IN-1:0] pv, input logic [2*N_IN-1:0] cv);
    logic m;
    m = row[ROW_W-1] & row[ROW_W-6+vidx(qc)];
    for (int i = 0; i < N_IN; i++)
      m = m & row[9*i + 3*vidx(pv[2*i+:2]) + vidx(cv[2*i+:2])];
    return m;
  endfunction

  always_comb begin
    found   = 1'b0;
    idx     = '0;
    changed = 1'b0;
    for (int i = 0; i < N_IN; i++)
      if (vidx(in_val[2*i+:2]) != vidx(prev[2*i+:2])) changed = 1'b1;
    // Scan downward so the lowest matching row is the one left standing
    for (int r = DEPTH-1; r >= 0; r--)
      if (row_match(tbl[r], q, prev, in_val)) begin
        found = 1'b1;
        idx   = AW'(r);
      end
    row_out = tbl[idx][ROW_W-2 -: 2];
    if (found)        q_next = (row_out == 2'b11) ? q : row_out;
    else if (changed) q_next = 2'b10;
    else              q_next = q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= INIT;
      prev    <= {N_IN{2'b10}};
      q_valid <= 1'b0;
      hit     <= 1'b0;
      hit_idx <= '0;
      uncov   <= 1'b0;
      for (int r = 0; r < DEPTH; r++) tbl[r] <= '0;
    end else begin
      // Evaluation above reads the pre-edge table, so a same-cycle write is seen next time
      if (cfg_we) tbl[cfg_addr] <= cfg_wdata;
      q_valid <= in_valid;
      if (in_valid) begin
        q       <= q_next;
        prev    <= in_val;
        hit     <= found;
        hit_idx <= found ? idx : '0;
        uncov   <= !found && changed;
      end else begin
        hit     <= 1'b0;
        hit_idx <= '0;
        uncov   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_udp_seq_engine.sv
// Bench for udp_seq_engine: directed table scenarios plus random traffic, all checked
// against a row-by-row behavioural model of the primitive.
module tb_udp_seq_engine;
  localparam int N_IN = 2, DEPTH = 16, AW = 4, ROW_W = 9*N_IN + 6;

  // transition masks, bit [3*prev+cur]
  localparam logic [8:0] L0 = 9'h049, L1 = 9'h092, LQ = 9'h1FF, LR = 9'h002, LS = 9'h0EE;

  logic              clk = 1'b0, rst_n = 1'b1, cfg_we = 1'b0, in_valid = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [ROW_W-1:0]  cfg_wdata = '0;
  logic [2*N_IN-1:0] in_val = '0;
  logic [1:0]        q;
  logic              q_valid, hit, uncov;
  logic [AW-1:0]     hit_idx;

  udp_seq_engine #(.N_IN(N_IN), .DEPTH(DEPTH), .INIT(2'b10)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .in_valid(in_valid), .in_val(in_val), .q(q), .q_valid(q_valid), .hit(hit),
    .hit_idx(hit_idx), .uncov(uncov));

  always #5 clk = ~clk;

  int vectors = 0, errs = 0;
  bit chk_en = 1'b0;

  logic [ROW_W-1:0] m_tbl [DEPTH];
  int               m_q;
  int               m_prev [N_IN];
  logic [1:0]       e_q;
  logic             e_qv, e_hit, e_uncov;
  logic [AW-1:0]    e_idx;

  function automatic int dec(logic [1:0] c);
    if (c[1]) return 2;
    return c[0] ? 1 : 0;
  endfunction

  function automatic logic [1:0] enc(int v);
    case (v)
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [ROW_W-1:0] mkrow(bit v, logic [1:0] o, logic [2:0] st,
                                             logic [8:0] t0, logic [8:0] t1);
    return {v, o, st, t1, t0};
  endfunction

  // does row r accept the step (q, prev) -> cur ?
  function automatic bit accepts(int r, logic [2*N_IN-1:0] cur);
    logic [2:0] st;
    logic [8:0] tm;
    if (!m_tbl[r][ROW_W-1]) return 0;
    st = m_tbl[r][ROW_W-4 -: 3];
    if (!st[m_q]) return 0;
    for (int i = 0; i < N_IN; i++) begin
      tm = m_tbl[r][9*i +: 9];
      if (!tm[3*m_prev[i] + dec(cur[2*i +: 2])]) return 0;
    end
    return 1;
  endfunction

  task automatic model_reset();
    m_q = 2;
    for (int i = 0; i < N_IN; i++) m_prev[i] = 2;
    for (int r = 0; r < DEPTH; r++) m_tbl[r] = '0;
    e_q = 2'b10; e_qv = 0; e_hit = 0; e_idx = '0; e_uncov = 0;
  endtask

  task automatic step(bit we, int addr, logic [ROW_W-1:0] wd, bit iv, logic [2*N_IN-1:0] val);
    bit found, chg;
    int idx;
    logic [1:0] o;
    @(negedge clk);
    cfg_we = we; cfg_addr = addr[AW-1:0]; cfg_wdata = wd; in_valid = iv; in_val = val;
    @(posedge clk);
    found = 0; idx = 0; chg = 0;
    if (iv) begin
      for (int r = 0; r < DEPTH; r++)
        if (!found && accepts(r, val)) begin found = 1; idx = r; end
      for (int i = 0; i < N_IN; i++)
        if (dec(val[2*i +: 2]) != m_prev[i]) chg = 1;
      if (found) begin
        o = m_tbl[idx][ROW_W-2 -: 2];
        if (o != 2'b11) m_q = dec(o);
      end else if (chg) m_q = 2;
      for (int i = 0; i < N_IN; i++) m_prev[i] = dec(val[2*i +: 2]);
    end
    if (we) m_tbl[addr] = wd;
    e_q = enc(m_q); e_qv = iv; e_hit = iv && found;
    e_idx = (iv && found) ? idx[AW-1:0] : '0;
    e_uncov = iv && !found && chg;
    #1;
    cfg_we = 0; in_valid = 0;
  endtask

  task automatic do_reset(bit mid_eval);
    @(negedge clk);
    cfg_we = 0; in_valid = mid_eval; in_val = 4'($urandom);
    #2 rst_n = 0;
    model_reset();
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic chk(string nm, logic [7:0] got, logic [7:0] want);
    vectors++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if ({q, q_valid, hit, hit_idx, uncov} !== {e_q, e_qv, e_hit, e_idx, e_uncov}) begin
        errs++;
        $display("FAIL cycle t=%0t q/qv/hit/idx/uncov: got %b/%b/%b/%0d/%b expected %b/%b/%b/%0d/%b",
                 $time, q, q_valid, hit, hit_idx, uncov, e_q, e_qv, e_hit, e_idx, e_uncov);
      end
    end
  end

  logic [ROW_W-1:0] rrow;

  initial begin
    #1 rst_n = 0;
    model_reset();
    chk_en = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk("reset q", q, 8'h02);
    chk("reset q_valid", q_valid, 8'h00);

    // reset arriving mid-stream discards a pending evaluation and empties the table
    step(1, 0, mkrow(1, 2'b01, 3'b111, LQ, LQ), 1, 4'b0000);
    do_reset(1);
    #1;
    chk("t1 q after reset", q, 8'h02);
    chk("t1 qv after reset", q_valid, 8'h00);
    step(0, 0, '0, 1, 4'b0101);
    chk("t1 q", q, 8'h02);
    chk("t1 uncov", uncov, 8'h01);
    chk("t1 hit", hit, 8'h00);

    // DFF-style table: in0 = clk, in1 = d
    step(1, 0, mkrow(1, 2'b00, 3'b111, LR, L0), 0, 4'b0000);
    step(1, 1, mkrow(1, 2'b01, 3'b111, LR, L1), 0, 4'b0000);
    step(1, 2, mkrow(1, 2'b11, 3'b111, LS, LQ), 0, 4'b0000);
    step(0, 0, '0, 1, 4'b0100);
    step(0, 0, '0, 1, 4'b0101);
    chk("t2 rise q", q, 8'h01);
    chk("t2 rise idx", hit_idx, 8'h01);
    step(0, 0, '0, 1, 4'b0100);
    chk("t2 fall q", q, 8'h01);
    chk("t2 fall hit", hit, 8'h01);
    chk("t2 fall idx", hit_idx, 8'h02);

    // priority between two matching rows
    for (int r = 0; r < 3; r++) step(1, r, '0, 0, 4'b0000);
    step(1, 3, mkrow(1, 2'b00, 3'b111, LQ, LQ), 0, 4'b0000);
    step(1, 7, mkrow(1, 2'b01, 3'b111, LQ, LQ), 0, 4'b0000);
    step(0, 0, '0, 1, 4'b0000);
    chk("t3 idx", hit_idx, 8'h03);
    chk("t3 q", q, 8'h00);
    step(1, 3, mkrow(0, 2'b00, 3'b111, LQ, LQ), 0, 4'b0000);
    step(0, 0, '0, 1, 4'b0000);
    chk("t3 idx after invalidate", hit_idx, 8'h07);
    chk("t3 q after invalidate", q, 8'h01);

    // uncovered falling edge on in0, then a repeat of the same value
    step(1, 7, '0, 0, 4'b0000);
    step(1, 0, mkrow(1, 2'b01, 3'b111, LR, LQ), 0, 4'b0000);
    step(0, 0, '0, 1, 4'b0001);
    step(0, 0, '0, 1, 4'b0000);
    chk("t4 q", q, 8'h02);
    chk("t4 uncov", uncov, 8'h01);
    step(0, 0, '0, 1, 4'b0000);
    chk("t4 hold q", q, 8'h02);
    chk("t4 hold uncov", uncov, 8'h00);
    chk("t4 hold hit", hit, 8'h00);

    // state mask gating
    step(1, 0, mkrow(1, 2'b01, 3'b001, LQ, LQ), 0, 4'b0000);
    step(1, 1, mkrow(1, 2'b01, 3'b100, LQ, LQ), 0, 4'b0000);
    step(0, 0, '0, 1, 4'b0000);
    step(0, 0, '0, 1, 4'b0000);
    chk("t5 q=1 hit", hit, 8'h00);
    chk("t5 q=1 q", q, 8'h01);
    step(1, 2, mkrow(1, 2'b00, 3'b010, LQ, LQ), 0, 4'b0000);
    step(0, 0, '0, 1, 4'b0000);
    chk("t5 to 0 q", q, 8'h00);
    step(0, 0, '0, 1, 4'b0000);
    chk("t5 q=0 idx", hit_idx, 8'h00);
    chk("t5 q=0 q", q, 8'h01);

    // same-cycle write and evaluate: old row0 applies, new row0 the time after
    step(1, 0, mkrow(1, 2'b10, 3'b111, LQ, LQ), 1, 4'b0000);
    chk("t6 same-cycle idx", hit_idx, 8'h02);
    chk("t6 same-cycle q", q, 8'h00);
    step(0, 0, '0, 1, 4'b0000);
    chk("t6 next idx", hit_idx, 8'h00);
    chk("t6 next q", q, 8'h02);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) do_reset(($urandom % 2) == 1);
      rrow = mkrow(($urandom % 4) != 0, 2'($urandom), 3'($urandom) | 3'($urandom),
                   9'($urandom) | 9'($urandom), 9'($urandom) | 9'($urandom));
      step(($urandom % 4) == 0, int'($urandom % DEPTH), rrow, ($urandom % 10) < 7, 4'($urandom));
    end

    @(negedge clk);
    #1;
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
